wishbone_slave: RTL
===================

# wishbone_slave

Wishbone classic-cycle responder for the 4-bit address / 8-bit data bus driven by `wishbone_master`. It implements a 16-entry register file: 14 read/write data registers, a read-only completed-transaction counter and a read-only ID register. It sits on the far side of the bus from the master and answers every strobed cycle with a single-cycle acknowledge after a programmable number of wait states. With `WB_SLV_ERR_EN` defined, it answers illegal writes with an error instead.

## Interface
Parameters:
- `WAIT_STATES`, default 1: extra cycles inserted between request accept and acknowledge. Legal range 0..15.
- `ID_VALUE`, default 8'hA5: constant returned when address 4'hF is read.

Ports:
- `clk`  input  1: single system clock; all logic on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `cyc_i`  input  1: bus cycle valid.
- `stb_i`  input  1: strobe; a request is `cyc_i & stb_i`.
- `we_i`  input  1: 1 = write, 0 = read.
- `adr_i`  input  4: register address.
- `dat_i`  input  8: write data.
- `dat_o`  output  8: read data. Valid only while `ack_o` = 1; 8'h00 otherwise.
- `ack_o`  output  1: normal termination, one-cycle pulse.
- `err_o`  output  1: error termination, one-cycle pulse. Always 0 unless `WB_SLV_ERR_EN` is defined.

## Operation
- **Register map:**
  - 4'h0..4'hD: read/write data registers, reset to 8'h00.
  - 4'hE: `txn_cnt`, read-only. Counts `ack_o` terminations and wraps 8'hFF -> 8'h00.
  - 4'hF: `ID_VALUE`, read-only.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - If `cyc_i & stb_i`: latch `adr_i`, `dat_i` and `we_i`, and load the wait counter with `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES` > 0, otherwise RESP.
- **WAIT:**
  - Decrement the counter. When it reaches 1, go to RESP.
  - If `cyc_i` = 0 in any WAIT cycle (abort): go to IDLE. No write, no response, no counter change.
- **RESP:**
  - Drive exactly one of `ack_o` / `err_o` high for one cycle, then go to IDLE unconditionally.
  - An abort (`cyc_i` = 0) seen in RESP is ignored; the response completes.
- **Writes:**
  - 0x0..0xD: the latched data is written on the clock edge that ends the RESP cycle.
  - 0xE or 0xF: no register changes. The cycle ends with `ack_o` (macro off) or `err_o` (macro on).
- **Reads:**
  - `dat_o` = the addressed register during RESP.
  - Reading 0xE returns the value before this cycle's increment.
- **Transaction counter:** `txn_cnt` increments on the edge ending every RESP cycle that drives `ack_o` (reads and writes). It does not increment for `err_o` cycles or aborts.
- **Back-to-back requests:** a request still asserted in the cycle after RESP (the FSM is back in IDLE) is accepted as a new transaction. Requests are never accepted in WAIT or RESP.
- **Reset** (`rst` = 1 at an edge) is valid in any state, including mid-transaction:
  - Forces IDLE, clears all data registers and `txn_cnt`, and `dat_o`/`ack_o`/`err_o` = 0.
  - An in-flight write is dropped.

## Timing
- Request sampled in IDLE at edge N -> response visible in cycle N+1+`WAIT_STATES`.
- Earliest new accept is at edge N+2+`WAIT_STATES`.
- Throughput is one transaction per `WAIT_STATES`+2 cycles.
- Outputs `ack_o`, `err_o` and `dat_o` are driven from registered state/data only; there are no combinational paths from inputs to outputs.
- Against `wishbone_master` with `WAIT_STATES` = 0: master SETUP at cycle S, `ack_o` at S+1, master done at S+2.

## Configuration
- `WB_SLV_ERR_EN` defined:
  - A write to 0xE or 0xF terminates with `err_o` = 1 and `ack_o` = 0.
  - No state changes: register file and `txn_cnt` are untouched.
- `WB_SLV_ERR_EN` undefined:
  - The `err_o` output is tied to 0.
  - A write to 0xE or 0xF is silently ignored and acked; `txn_cnt` increments.

## Test plan
- **Reset values:** after reset, read every address with `WAIT_STATES`=1 -> 0x0..0xD return 8'h00, 0xE returns 8'h00, 0xF returns 8'hA5. Each `ack_o` arrives exactly 2 cycles after the accept edge.
- **Write/read-back:** write 8'h3C to 4'h2, then read 4'h2 -> `dat_o` = 8'h3C with `ack_o`. A following read of 4'hE returns 8'h02.
- **Abort:**
  - `WAIT_STATES`=3, write 8'hFF to 4'h5, drop `cyc_i` in the second WAIT cycle -> no `ack_o`.
  - Reading 4'h5 then returns 8'h00 and `txn_cnt` is unchanged.
- **Read-only write:** write 8'h11 to 4'hF.
  - Macro on: `err_o` pulse, `ack_o` = 0, `txn_cnt` unchanged.
  - Macro off: `ack_o` pulse, `txn_cnt` +1.
  - In both builds, a read of 4'hF returns 8'hA5.
- **Counter wrap and back-to-back:** hold `cyc_i`/`stb_i` high for 256 reads of 4'h0 with `WAIT_STATES`=0 -> `ack_o` every 2nd cycle, and `txn_cnt` reads 8'h00 afterwards.
- **Mid-cycle reset:** assert `rst` during WAIT of a write of 8'h77 to 4'h1 -> `ack_o` stays 0, and after release 4'h1 reads 8'h00.

Source files
------------

// File: rtl/wishbone_slave_if.sv
// Bus signals between a Wishbone classic master and wishbone_slave
// (4-bit address, 8-bit data). Signal names are from the slave's point of view.
interface wishbone_slave_if;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [3:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wishbone_slave.sv
// Wishbone classic-cycle responder with a 16-entry register file:
//   0x0..0xD read/write data, 0xE completed-transaction counter (RO),
//   0xF ID_VALUE (RO).
// Every strobed cycle is answered after WAIT_STATES wait cycles with a
// one-cycle ack_o. Optional feature macro: WB_SLV_ERR_EN -- when defined,
// writes to the read-only addresses terminate with err_o instead of ack_o.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for cyc_i & stb_i; request fields latched on accept
// ST_WAIT | counting wait states; cyc_i low here aborts the transaction
// ST_RESP | ack_o or err_o high for one cycle; writes commit at its end
module wishbone_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  wishbone_slave_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] LP_WAIT  = 4'(WAIT_STATES);
  localparam logic [3:0] LP_N_REG = 4'd14;
`ifdef WB_SLV_ERR_EN
  localparam bit LP_ERR_EN = 1'b1;
`else
  localparam bit LP_ERR_EN = 1'b0;
`endif

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_adr;
  logic       r_we;
  logic [7:0] r_wdat;
  logic [7:0] r_txn;
  logic [7:0] r_rdat;
  logic       r_ack;
  logic       r_err;
  logic [7:0] r_regs [14];

  logic       w_req;
  logic       w_enter_resp;
  logic [3:0] w_adr;
  logic       w_we;
  logic [7:0] w_rval;
  logic       w_err_next;

  // With zero wait states the response is prepared straight from the bus
  // inputs on the accept edge; otherwise from the latched request.
  always_comb begin
    w_req        = bus.cyc_i & bus.stb_i;
    w_adr        = (r_state == ST_IDLE) ? bus.adr_i : r_adr;
    w_we         = (r_state == ST_IDLE) ? bus.we_i : r_we;
    w_enter_resp = ((r_state == ST_IDLE) && w_req && (LP_WAIT == 4'd0)) ||
                   ((r_state == ST_WAIT) && bus.cyc_i && (r_cnt == 4'd1));
    w_err_next   = LP_ERR_EN && w_we && (w_adr >= LP_N_REG);
    w_rval       = 8'h00;
    if (w_adr == 4'hE)      w_rval = r_txn;
    else if (w_adr == 4'hF) w_rval = ID_VALUE;
    else                    w_rval = r_regs[w_adr];
  end

  // Transaction FSM, register file, counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_adr   <= 4'd0;
      r_we    <= 1'b0;
      r_wdat  <= 8'h00;
      r_txn   <= 8'h00;
      r_rdat  <= 8'h00;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 14; i++) r_regs[i] <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr   <= bus.adr_i;
            r_we    <= bus.we_i;
            r_wdat  <= bus.dat_i;
            r_cnt   <= LP_WAIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.cyc_i)               r_state <= ST_IDLE;
          else if (r_cnt != 4'd1)       r_cnt   <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          // Abort is not checked here: the response always completes.
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rdat  <= 8'h00;
          if (r_ack) begin
            r_txn <= r_txn + 8'h01;
            if (r_we && (r_adr < LP_N_REG)) r_regs[r_adr] <= r_wdat;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_enter_resp) begin
        r_state <= ST_RESP;
        r_ack   <= ~w_err_next;
        r_err   <= w_err_next;
        r_rdat  <= w_we ? 8'h00 : w_rval;
      end
    end
  end

  assign bus.ack_o = r_ack;
  assign bus.err_o = r_err;
  assign bus.dat_o = r_rdat;

endmodule
